hilo_ctrl: RTL and testbench
============================

# hilo_ctrl

Multiply/divide sequencer that owns all writes into the HI/LO register pair. Accepts HI/LO-class instructions from the EX stage, runs a single-cycle-registered multiplier or a 32-iteration restoring divider, and holds the pipeline through `stall` until the result is ready. Drives the HI/LO register write port (`hilo_we`, `hi_o`, `lo_o`) and reads its current contents back for accumulate ops.

## Interface
- No parameters; data width fixed at 32.
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `op_valid`  in  1  EX holds a HI/LO-class instruction
- `op`  in  4  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 MADDU, 8 MSUB, 9 MSUBU; 10-15 no-op
- `rs_val`  in  32  operand A (dividend / MTHI/MTLO source)
- `rt_val`  in  32  operand B (divisor)
- `flush`  in  1  kill in-flight operation
- `hi_cur`, `lo_cur`  in  32 each  current HI/LO register contents
- `stall`  out  1  hold IF..EX this cycle
- `busy`  out  1  state != IDLE
- `hilo_we`  out  1  HI/LO write strobe, one-cycle pulse
- `hi_o`, `lo_o`  out  32 each  write data

## Operation
- States: IDLE, MUL, DIV, FIX, DONE.
- IDLE, `op_valid`, no `flush`:
  - MULT/MULTU/MADD*/MSUB*: latch operands, go MUL.
  - DIV/DIVU, `rt_val`≠0: latch magnitudes (signed ops) or raw values, clear the 32-bit partial remainder, go DIV.
  - DIV/DIVU, `rt_val`=0: go DONE with hi=`rs_val`, lo=32'hFFFFFFFF.
  - MTHI: next cycle pulse `hilo_we` with hi=`rs_val`, lo=`lo_cur`. State stays IDLE, no stall. MTLO mirrors this.
- MUL: register 64-bit product, signed for MULT/MADD/MSUB, unsigned otherwise; go DONE.
- DIV: one restoring step per cycle, 32-cycle counter; after step 32 go FIX.
- FIX, signed DIV: negate quotient if operand signs differ; remainder takes the dividend's sign. Go DONE.
- DONE: `hilo_we`=1. For MADD*/MSUB*, {hi,lo} = {`hi_cur`,`lo_cur`} ± product, mod 2^64, using `hi_cur`/`lo_cur` sampled this cycle. For MULT*, {hi,lo} = product. For DIV*, hi=remainder, lo=quotient. `op_valid` is ignored this cycle because the held instruction is being released. Go IDLE.
- `stall` = (IDLE ∧ `op_valid` ∧ op∈{0-3,6-9} ∧ ¬`flush`) ∨ state∈{MUL,DIV,FIX}. `stall` is low in DONE.
- `flush`: force IDLE next cycle, deassert `stall` the same cycle, suppress `hilo_we` the same cycle (including a pending MTHI/MTLO write), ignore `op_valid`.
- Reset: state IDLE; `stall`, `busy`, `hilo_we` = 0; `hi_o`, `lo_o` = 0.

## Timing
- Accept cycle = N (IDLE, `op_valid` sampled).
- MTHI/MTLO: `hilo_we` at N+1. The HI/LO register updates at the end of N+1. The next op can be accepted at N+1.
- MULT-class: `stall` high N, N+1. DONE and `hilo_we` at N+2.
- DIV-class: `stall` high N..N+33. DIV covers N+1..N+32, FIX is N+33, DONE is N+34.
- Divide by zero: `stall` high N. DONE at N+1.
- Back-to-back: after an MTHI at N, an accumulate op accepted at N+1 reads the updated `hi_cur` in its DONE.
- `hilo_we` is never asserted in two consecutive cycles from the same instruction.

## Configuration
- `HILO_MADD_EN` defined: ops 6-9 are implemented as above.
- `HILO_MADD_EN` undefined: ops 6-9 behave like 10-15. They are accepted as no-ops, with no `stall` and no write. The accumulate adder and the `hi_cur`/`lo_cur` path are removed.

## Test plan
- MULT rs=32'hFFFFFFFF, rt=2 -> `stall` high for 2 cycles; at N+2 `hilo_we`=1, hi=FFFFFFFF, lo=FFFFFFFE.
- MULTU with the same operands -> hi=00000001, lo=FFFFFFFE at N+2.
- DIV rs=-7, rt=2 -> `stall` high N..N+33; at N+34 lo=FFFFFFFD, hi=FFFFFFFF. DIVU 7/0 -> N+1 hi=7, lo=FFFFFFFF.
- MTHI rs=5 at N, then MADD 3×4 at N+1 with lo_cur=0 -> writes at N+1 (hi=5) and at N+3 (hi=5, lo=0000000C).
- `flush` at N+10 of a DIV -> `stall` low at N+10, no `hilo_we` through N+40, `busy` low at N+11.
- `rst` asserted mid-MUL -> all outputs 0 the next cycle; a new MULTU is accepted immediately after reset release.

Source files
------------

// File: rtl/hilo_ctrl.sv
// hilo_ctrl: multiply/divide sequencer owning the HI/LO register write port.
// Optional feature macro HILO_MADD_EN enables MADD/MADDU/MSUB/MSUBU (ops 6-9).
module hilo_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [3:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        flush,
  input  logic [31:0] hi_cur,
  input  logic [31:0] lo_cur,
  output logic        stall,
  output logic        busy,
  output logic        hilo_we,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_e;

  typedef enum logic [3:0] {
    OP_MULT  = 4'd0, OP_MULTU = 4'd1, OP_DIV  = 4'd2, OP_DIVU  = 4'd3,
    OP_MTHI  = 4'd4, OP_MTLO  = 4'd5, OP_MADD = 4'd6, OP_MADDU = 4'd7,
    OP_MSUB  = 4'd8, OP_MSUBU = 4'd9
  } op_e;

  function automatic logic op_signed(input logic [3:0] o);
    return (o == OP_MULT) || (o == OP_DIV) || (o == OP_MADD) || (o == OP_MSUB);
  endfunction

  function automatic logic op_mul(input logic [3:0] o);
`ifdef HILO_MADD_EN
    return (o == OP_MULT) || (o == OP_MULTU) || (o == OP_MADD) ||
           (o == OP_MADDU) || (o == OP_MSUB) || (o == OP_MSUBU);
`else
    return (o == OP_MULT) || (o == OP_MULTU);
`endif
  endfunction

  function automatic logic op_div(input logic [3:0] o);
    return (o == OP_DIV) || (o == OP_DIVU);
  endfunction

  state_e      state_q, state_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] a_q, a_d;        // multiplicand, or dividend shifting into quotient
  logic [31:0] b_q, b_d;
  logic [31:0] rem_q, rem_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] prod_q, prod_d;  // product, or {remainder, quotient}
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;
  logic        pend_q, pend_d;
  logic        pend_hi_q, pend_hi_d;
  logic [31:0] pend_val_q, pend_val_d;

  logic [32:0] sh;
  logic        ge;
  logic [63:0] ext_a, ext_b;
  logic        rs_neg, rt_neg;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    rem_d      = rem_q;
    cnt_d      = cnt_q;
    prod_d     = prod_q;
    qneg_d     = qneg_q;
    rneg_d     = rneg_q;
    pend_d     = 1'b0;
    pend_hi_d  = pend_hi_q;
    pend_val_d = pend_val_q;

    sh     = {rem_q, a_q[31]};
    ge     = sh >= {1'b0, b_q};
    ext_a  = op_signed(op_q) ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
    ext_b  = op_signed(op_q) ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
    rs_neg = op_signed(op) && rs_val[31];
    rt_neg = op_signed(op) && rt_val[31];

    unique case (state_q)
      S_IDLE: begin
        if (op_valid && !flush) begin
          if (op_mul(op)) begin
            op_d    = op;
            a_d     = rs_val;
            b_d     = rt_val;
            state_d = S_MUL;
          end else if (op_div(op)) begin
            op_d = op;
            if (rt_val == '0) begin
              prod_d  = {rs_val, 32'hFFFF_FFFF};
              state_d = S_DONE;
            end else begin
              a_d     = rs_neg ? -rs_val : rs_val;
              b_d     = rt_neg ? -rt_val : rt_val;
              rem_d   = '0;
              cnt_d   = '0;
              qneg_d  = rs_neg ^ rt_neg;
              rneg_d  = rs_neg;
              state_d = S_DIV;
            end
          end else if (op == OP_MTHI || op == OP_MTLO) begin
            pend_d     = 1'b1;
            pend_hi_d  = (op == OP_MTHI);
            pend_val_d = rs_val;
          end
        end
      end
      S_MUL: begin
        prod_d  = ext_a * ext_b;
        state_d = S_DONE;
      end
      S_DIV: begin
        rem_d = ge ? (sh[31:0] - b_q) : sh[31:0];
        a_d   = {a_q[30:0], ge};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = S_FIX;
      end
      S_FIX: begin
        prod_d  = {rneg_q ? -rem_q : rem_q, qneg_q ? -a_q : a_q};
        state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (flush) begin
      state_d = S_IDLE;
      pend_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
      prod_q     <= '0;
      qneg_q     <= 1'b0;
      rneg_q     <= 1'b0;
      pend_q     <= 1'b0;
      pend_hi_q  <= 1'b0;
      pend_val_q <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      rem_q      <= rem_d;
      cnt_q      <= cnt_d;
      prod_q     <= prod_d;
      qneg_q     <= qneg_d;
      rneg_q     <= rneg_d;
      pend_q     <= pend_d;
      pend_hi_q  <= pend_hi_d;
      pend_val_q <= pend_val_d;
    end
  end

  // Write port is combinational so flush can kill a write in the same cycle.
  always_comb begin
    hilo_we = 1'b0;
    hi_o    = '0;
    lo_o    = '0;
    if (!flush) begin
      if (state_q == S_DONE) begin
        hilo_we      = 1'b1;
        {hi_o, lo_o} = prod_q;
`ifdef HILO_MADD_EN
        if (op_q == OP_MADD || op_q == OP_MADDU)
          {hi_o, lo_o} = {hi_cur, lo_cur} + prod_q;
        else if (op_q == OP_MSUB || op_q == OP_MSUBU)
          {hi_o, lo_o} = {hi_cur, lo_cur} - prod_q;
`endif
      end else if (state_q == S_IDLE && pend_q) begin
        hilo_we = 1'b1;
        hi_o    = pend_hi_q ? pend_val_q : hi_cur;
        lo_o    = pend_hi_q ? lo_cur : pend_val_q;
      end
    end
  end

  assign busy  = (state_q != S_IDLE);
  assign stall = !flush &&
                 ((state_q == S_IDLE && op_valid && (op_mul(op) || op_div(op))) ||
                  state_q == S_MUL || state_q == S_DIV || state_q == S_FIX);

endmodule

// File: tb/tb_hilo_ctrl.sv
// Scoreboard bench for hilo_ctrl: stimulus queues expected HI/LO writes, a monitor checks them.
module tb_hilo_ctrl;

  logic        clk;
  logic        rst;
  logic        op_valid;
  logic [3:0]  op;
  logic [31:0] rs_val, rt_val;
  logic        flush;
  logic [31:0] hi_cur, lo_cur;
  logic        stall, busy, hilo_we;
  logic [31:0] hi_o, lo_o;

  hilo_ctrl dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op(op),
    .rs_val(rs_val), .rt_val(rt_val), .flush(flush),
    .hi_cur(hi_cur), .lo_cur(lo_cur),
    .stall(stall), .busy(busy), .hilo_we(hilo_we), .hi_o(hi_o), .lo_o(lo_o)
  );

  typedef struct {
    int unsigned cyc;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  int unsigned cyc;
  int unsigned wecount;
  int          tests;
  int          fails;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // HI/LO register file fed by the DUT write port
  always @(posedge clk) begin
    if (rst) begin
      hi_cur <= '0;
      lo_cur <= '0;
    end else if (hilo_we) begin
      hi_cur <= hi_o;
      lo_cur <= lo_o;
    end
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %h, required %h", nm, cyc, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (hilo_we === 1'b1) begin
      wecount++;
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write @cyc %0d: hi %h lo %h, required no write", cyc, hi_o, lo_o);
      end else begin
        mon_e = q.pop_front();
        chk("write_cycle", 64'(cyc), 64'(mon_e.cyc));
        chk("write_data", {hi_o, lo_o}, {mon_e.hi, mon_e.lo});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op in the current cycle, hold it while stalled and through DONE.
  task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int nst, input bit we, input logic [31:0] eh, input logic [31:0] el);
    int unsigned n;
    int sc;
    n  = cyc;
    sc = 0;
    op_valid = 1'b1;
    op       = o;
    rs_val   = a;
    rt_val   = b;
    if (we) q.push_back('{n + ((nst > 0) ? nst : 1), eh, el});
    for (int i = 0; i < nst; i++) begin
      @(negedge clk);
      if (stall) sc++;
      tick();
    end
    @(negedge clk);
    chk("stall_cycles", 64'(sc), 64'(nst));
    chk("stall_low_after", 64'(stall), 64'd0);
    chk("busy_at_release", 64'(busy), 64'(nst > 0));
    tick();
    op_valid = 1'b0;
    op       = 4'hF;
  endtask

  initial begin
    int unsigned w0;
    tests = 0; fails = 0; cyc = 0; wecount = 0;
    rst = 1'b1; op_valid = 1'b0; op = 4'hF; rs_val = '0; rt_val = '0; flush = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("reset_outputs", {29'd0, stall, busy, hilo_we}, 32'd0);
    chk("reset_data", {hi_o, lo_o}, 64'd0);
    tick();
    rst = 1'b0;
    tick();

    run_op(4'd0, 32'hFFFF_FFFF, 32'd2, 2, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFE);   // MULT
    run_op(4'd1, 32'hFFFF_FFFF, 32'd2, 2, 1, 32'h0000_0001, 32'hFFFF_FFFE);   // MULTU
    run_op(4'd0, 32'h8000_0000, 32'h8000_0000, 2, 1, 32'h4000_0000, 32'h0);  // MULT min*min
    run_op(4'd2, 32'hFFFF_FFF9, 32'd2, 34, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFD); // DIV -7/2
    run_op(4'd3, 32'd100, 32'd7, 34, 1, 32'd2, 32'd14);                      // DIVU
    run_op(4'd2, 32'h8000_0000, 32'hFFFF_FFFF, 34, 1, 32'd0, 32'h8000_0000); // DIV min/-1
    run_op(4'd3, 32'd7, 32'd0, 1, 1, 32'd7, 32'hFFFF_FFFF);                  // DIVU /0
    run_op(4'd2, 32'hFFFF_FFFB, 32'd0, 1, 1, 32'hFFFF_FFFB, 32'hFFFF_FFFF);  // DIV /0
    run_op(4'd12, 32'd1, 32'd1, 0, 0, 32'd0, 32'd0);                         // no-op

    // MTLO then MTHI then accumulate, back to back
    run_op(4'd5, 32'd0, 32'd0, 0, 1, 32'hFFFF_FFFB, 32'd0);
    run_op(4'd4, 32'd5, 32'd0, 0, 1, 32'd5, 32'd0);
`ifdef HILO_MADD_EN
    run_op(4'd6, 32'd3, 32'd4, 2, 1, 32'd5, 32'h0000_000C);                  // MADD
    run_op(4'd9, 32'd3, 32'd5, 2, 1, 32'd4, 32'hFFFF_FFFD);                  // MSUBU
`else
    run_op(4'd6, 32'd3, 32'd4, 0, 0, 32'd0, 32'd0);
    run_op(4'd9, 32'd3, 32'd5, 0, 0, 32'd0, 32'd0);
`endif

    // Flush kills a pending MTHI write and blocks a DIV offered in the same cycle
    tick();
    op_valid = 1'b1; op = 4'd4; rs_val = 32'h1234_5678;
    tick();
    flush = 1'b1; op = 4'd2; rs_val = 32'd9; rt_val = 32'd3;
    @(negedge clk);
    chk("flush_we_pending", 64'(hilo_we), 64'd0);
    chk("flush_stall_idle", 64'(stall), 64'd0);
    tick();
    flush = 1'b0; op_valid = 1'b0; op = 4'hF;
    @(negedge clk);
    chk("flush_busy_idle", 64'(busy), 64'd0);
    tick();

    // Flush a DIV at N+10
    w0 = wecount;
    op_valid = 1'b1; op = 4'd2; rs_val = 32'd100; rt_val = 32'd3;
    repeat (10) tick();
    flush = 1'b1;
    @(negedge clk);
    chk("flush_div_stall", 64'(stall), 64'd0);
    tick();
    flush = 1'b0; op_valid = 1'b0; op = 4'hF;
    @(negedge clk);
    chk("flush_div_busy", 64'(busy), 64'd0);
    repeat (30) tick();
    chk("flush_div_no_write", 64'(wecount), 64'(w0));

    // Reset in the middle of a MULT, then MULTU right after release
    op_valid = 1'b1; op = 4'd0; rs_val = 32'd3; rt_val = 32'd4;
    tick();
    op_valid = 1'b0; op = 4'hF; rst = 1'b1;
    tick();
    @(negedge clk);
    chk("rst_mid_ctl", {29'd0, stall, busy, hilo_we}, 32'd0);
    chk("rst_mid_data", {hi_o, lo_o}, 64'd0);
    tick();
    rst = 1'b0;
    run_op(4'd1, 32'd6, 32'd7, 2, 1, 32'd0, 32'h0000_002A);
    repeat (3) tick();

    chk("scoreboard_empty", 64'(q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
